adau_spi_master: RTL and testbench
==================================

Name: adau_spi_master

Overview:
- SPI master for the ADAU codec control port; sits directly downstream of adau_command_list.
- Accepts one 32-bit command word per valid/ready handshake: [31:24] chip-address/RW byte, [23:8] register address, [7:0] data.
- Serialises the word MSB-first on CCLK/CDATA/CLATCH_N.
- Holds spi_ready low until the frame and the inter-frame gap are complete, so the command list can gate adau_init_done on spi_ready.

Parameters:
- CLK_DIV, 4, system clocks per SPI half-period; legal range >= 1.
- CS_GAP, 8, system clocks CLATCH_N is held high after each frame before spi_ready returns; legal range >= 1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE
- command  in  32  word to send; sampled only on accept
- command_valid  in  1  upstream has a word
- spi_ready  out  1  high only in IDLE; accept = command_valid && spi_ready at a posedge
- spi_clk  out  1  CCLK; CPOL=1, idles high
- spi_mosi  out  1  CDATA
- spi_cs_n  out  1  CLATCH_N, active low

Behaviour:
- Reset values, asynchronous: state=IDLE, spi_ready=1, spi_clk=1, spi_mosi=0, spi_cs_n=1, shift register=0, counters=0.
- All outputs are registered or decoded from registered state only. No combinational path from command_valid to any output.
- IDLE:
  - spi_ready=1, spi_cs_n=1, spi_clk=1.
  - On accept: load command into the shift register and go to SETUP.
  - spi_ready is 0 from the cycle after the accept edge.
- SETUP, CLK_DIV cycles: spi_cs_n=0, spi_clk=1, spi_mosi=command[31].
- SHIFT, 32 bits of 2*CLK_DIV cycles each:
  - Low phase (CLK_DIV cycles): spi_clk=0; spi_mosi updates to the current bit on entry to this phase.
  - High phase (CLK_DIV cycles): spi_clk=1; the codec samples on this rising edge.
  - Bit order is 31 down to 0. The bit counter is 5 bits wide and ends after bit 0; it does not wrap into a 33rd bit.
- HOLD, CLK_DIV cycles: spi_cs_n=0, spi_clk=1, spi_mosi holds bit 0.
- GAP, CS_GAP cycles: spi_cs_n=1, spi_clk=1, spi_mosi=0. Then go to IDLE.
- Latency: spi_ready returns high exactly (66*CLK_DIV + CS_GAP) cycles after the accept edge. With defaults this is 272 cycles.
- Back-to-back: if command_valid is held high, the next accept happens on the first IDLE cycle. Minimum frame period = 66*CLK_DIV + CS_GAP + 1 cycles.
- command and command_valid changing while busy: ignored. The loaded word is never altered mid-frame.
- command_valid dropping before accept: no transfer, outputs stay at IDLE values.
- Reset mid-frame: the frame aborts immediately. spi_cs_n=1 and spi_clk=1 in the same instant (asynchronous), and spi_ready=1. No partial frame resumes after reset.
- Frame content is not interpreted. The dummy all-zero words used for SPI-mode entry are sent like any other word.

Optional Feature:
- Macro ADAU_SPI_READBACK_EN.
- When defined:
  - Adds ports spi_miso in 1 (COUT), read_data out 8, and read_valid out 1.
  - spi_miso is sampled into an 8-bit shift register on the last system cycle of each high phase.
  - On entry to GAP, read_data is loaded with the last 8 sampled bits (bits sampled during data bits 7..0) and read_valid pulses high for exactly 1 cycle.
  - Reset values: read_data=0, read_valid=0. read_data holds its value until the next frame completes.
  - An aborted frame produces no read_valid.
- When undefined: the three ports do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then idle 20 cycles with command_valid=0 -> spi_ready=1, spi_cs_n=1, spi_clk=1, spi_mosi=0 throughout.
- Send 32'h0040_1C21 with defaults:
  - Capture spi_mosi on each spi_clk rise: exactly 32 bits, reconstructing 32'h00401C21.
  - spi_cs_n low for 264 cycles.
  - spi_ready high again exactly 272 cycles after the accept edge.
- Change command to 32'hFFFF_FFFF one cycle after accepting 32'h0040_4000 -> transmitted bits are still 32'h00404000; command_valid stays high and the next accept occurs on cycle 273.
- Stream the 15-word adau_command_list sequence (3x 32'h0, 32'h00400001 ... 32'h0040FA01) with command_valid held high -> 15 frames, each with correct content; spi_cs_n high for exactly 9 cycles between frames (CS_GAP plus the accept cycle).
- Assert reset after 100 cycles into a frame -> spi_cs_n=1 and spi_clk=1 before the next clk edge, spi_ready=1; a new word sent afterwards is transmitted fully.
- ADAU_SPI_READBACK_EN defined, spi_miso driven with 32'h0000_00A5 MSB-first aligned to the frame -> read_data=8'hA5 and read_valid high for 1 cycle at GAP entry; no pulse after a frame aborted by reset.

Source files
------------

// File: rtl/adau_spi_master.sv
// SPI master for the ADAU codec control port: one 32-bit word per handshake, MSB-first, CPOL=1.
// Define ADAU_SPI_READBACK_EN to add COUT capture (spi_miso, read_data, read_valid).
module adau_spi_master #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] command,
    input  logic        command_valid,
    output logic        spi_ready,
    output logic        spi_clk,
    output logic        spi_mosi,
    output logic        spi_cs_n
`ifdef ADAU_SPI_READBACK_EN
    ,
    input  logic        spi_miso,
    output logic [7:0]  read_data,
    output logic        read_valid
`endif
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SETUP    = 3'd1;
    localparam logic [2:0] ST_SHIFT_LO = 3'd2;
    localparam logic [2:0] ST_SHIFT_HI = 3'd3;
    localparam logic [2:0] ST_HOLD     = 3'd4;
    localparam logic [2:0] ST_GAP      = 3'd5;

    // One phase counter serves every timed state, so it is sized for the longer of the two.
    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);

    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("adau_spi_master: CLK_DIV must be >= 1");
        end
        if (CS_GAP < 1) begin : g_bad_gap
            $error("adau_spi_master: CS_GAP must be >= 1");
        end
    endgenerate

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       bit_q, bit_d;
    logic [31:0]      shreg_q, shreg_d;
    logic             ready_q, ready_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic             div_last;
    logic             gap_last;

    assign div_last = (cnt_q == DIV_LAST);
    assign gap_last = (cnt_q == GAP_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        ready_d = ready_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b1;
                mosi_d  = 1'b0;
                if (command_valid) begin
                    shreg_d = command;
                    state_d = ST_SETUP;
                    ready_d = 1'b0;
                    cs_n_d  = 1'b0;
                    mosi_d  = command[31];
                    cnt_d   = '0;
                    bit_d   = 5'd31;
                end
            end

            ST_SETUP: begin
                if (div_last) begin
                    state_d = ST_SHIFT_LO;
                    cnt_d   = '0;
                    sclk_d  = 1'b0;
                    mosi_d  = shreg_q[bit_q];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_SHIFT_LO: begin
                if (div_last) begin
                    state_d = ST_SHIFT_HI;
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_SHIFT_HI: begin
                if (div_last) begin
                    cnt_d = '0;
                    // Bit 0 ends the shift; the counter never steps below zero.
                    if (bit_q == 5'd0) begin
                        state_d = ST_HOLD;
                    end else begin
                        bit_d   = bit_q - 5'd1;
                        state_d = ST_SHIFT_LO;
                        sclk_d  = 1'b0;
                        mosi_d  = shreg_q[bit_q - 5'd1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_HOLD: begin
                if (div_last) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_GAP: begin
                if (gap_last) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
                ready_d = 1'b1;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b1;
                mosi_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            ready_q <= 1'b1;
            sclk_q  <= 1'b1;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            ready_q <= ready_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
        end
    end

    assign spi_ready = ready_q;
    assign spi_clk   = sclk_q;
    assign spi_mosi  = mosi_q;
    assign spi_cs_n  = cs_n_q;

`ifdef ADAU_SPI_READBACK_EN
    logic [7:0] miso_sr_q;
    logic       sample_en;
    logic       gap_entry;

    // COUT is taken at the end of each high phase, just before CCLK falls.
    assign sample_en = (state_q == ST_SHIFT_HI) && div_last;
    assign gap_entry = (state_q == ST_HOLD) && div_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miso_sr_q  <= '0;
            read_data  <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= gap_entry;
            if (sample_en) begin
                miso_sr_q <= {miso_sr_q[6:0], spi_miso};
            end
            if (gap_entry) begin
                read_data <= miso_sr_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_adau_spi_master.sv
// Self-checking bench for adau_spi_master: directed frames, streaming, reset abort and randomized words.
// Readback checks are compiled in when ADAU_SPI_READBACK_EN is defined.
module tb_adau_spi_master;

    localparam int CD         = 4;
    localparam int CG         = 8;
    localparam int FRAME_LAT  = 66 * CD + CG;
    localparam int CS_LOW     = 66 * CD;
    localparam int PERIOD     = FRAME_LAT + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] command = '0;
    logic        command_valid = 1'b0;
    logic        spi_ready;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_cs_n;
`ifdef ADAU_SPI_READBACK_EN
    logic        spi_miso = 1'b0;
    logic [7:0]  read_data;
    logic        read_valid;
    int          rv_high = 0;
    int          rv_cyc = 0;
    logic [7:0]  rd_cap = '0;
`endif

    always #5 clk = ~clk;

    adau_spi_master #(.CLK_DIV(CD), .CS_GAP(CG)) dut (
        .clk           (clk),
        .reset         (reset),
        .command       (command),
        .command_valid (command_valid),
        .spi_ready     (spi_ready),
        .spi_clk       (spi_clk),
        .spi_mosi      (spi_mosi),
        .spi_cs_n      (spi_cs_n)
`ifdef ADAU_SPI_READBACK_EN
        ,
        .spi_miso      (spi_miso),
        .read_data     (read_data),
        .read_valid    (read_valid)
`endif
    );

    int          n_checks = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          rx_cnt = 0;
    logic [31:0] rx_word = '0;
    int          cs_low_run = 0;
    int          cs_high_run = 0;
    int          last_low = 0;
    int          gap_len = 0;
    int          idle_bad = 0;
    logic        first_mosi = 1'b0;
    logic        prev_cs = 1'b1;
    logic        prev_clk = 1'b1;
    int          acc_cyc = 0;
    int          prev_acc = 0;
    logic [31:0] miso_word = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle and observe the bus at the falling system clock edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!spi_cs_n) begin
            if (prev_cs) begin
                gap_len    = cs_high_run;
                rx_cnt     = 0;
                rx_word    = '0;
                cs_low_run = 0;
                first_mosi = spi_mosi;
            end
            cs_low_run++;
            if (spi_clk && !prev_clk) begin
                rx_word = {rx_word[30:0], spi_mosi};
                rx_cnt++;
            end
        end else begin
            if (!prev_cs) begin
                last_low    = cs_low_run;
                cs_high_run = 0;
            end
            cs_high_run++;
            if (!spi_clk || spi_mosi) idle_bad++;
        end
        prev_cs  = spi_cs_n;
        prev_clk = spi_clk;
`ifdef ADAU_SPI_READBACK_EN
        if (read_valid) begin
            rv_high++;
            rd_cap = read_data;
            rv_cyc = cyc;
        end
        if (!spi_cs_n && !spi_clk && rx_cnt < 32) spi_miso = miso_word[31 - rx_cnt];
`endif
    endtask

    task automatic wait_accept();
        int g;
        g = 0;
        while (!spi_ready && g < 1000) begin
            tick();
            g++;
        end
        check("accept_ready", {31'd0, spi_ready}, 32'd1);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [31:0] w, input bit keep_valid, input logic [31:0] next_cmd,
                              input bit junk, input logic [31:0] mw, input bit chk_link);
        int n;
        bit done;
`ifdef ADAU_SPI_READBACK_EN
        int rv0;
        rv0 = rv_high;
`endif
        miso_word     = mw;
        command       = w;
        command_valid = 1'b1;
        wait_accept();
        if (!keep_valid) command_valid = 1'b0;
        command = next_cmd;
        if (chk_link) check("accept_period", acc_cyc - prev_acc, PERIOD);
        prev_acc = acc_cyc;
        n = 0;
        done = 1'b0;
        while (!done && n < 2 * FRAME_LAT) begin
            tick();
            n++;
            if (n == 1) check("busy_after_accept", {31'd0, spi_ready}, 32'd0);
            if (junk) begin
                command       = $urandom;
                command_valid = (n < 250) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            done = spi_ready;
        end
        check("ready_latency", n - 1, FRAME_LAT);
        check("bit_count", rx_cnt, 32);
        check("frame_word", rx_word, w);
        check("cs_low_len", last_low, CS_LOW);
        check("setup_mosi", {31'd0, first_mosi}, {31'd0, w[31]});
        check("idle_lines", idle_bad, 0);
        if (chk_link) check("cs_gap_len", gap_len, CG + 1);
`ifdef ADAU_SPI_READBACK_EN
        check("read_valid_len", rv_high - rv0, 1);
        check("read_data", {24'd0, rd_cap}, {24'd0, mw[7:0]});
        check("read_valid_time", rv_cyc - acc_cyc, CS_LOW + 1);
`endif
    endtask

    logic [31:0] seq [15] = '{
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
        32'h0040_0001, 32'h0040_1C21, 32'h0040_1E00, 32'h0040_2000,
        32'h0040_2100, 32'h0040_2900, 32'h0040_2A03, 32'h0040_F201,
        32'h0040_F501, 32'h0040_F601, 32'h0040_F901, 32'h0040_FA01
    };

    initial begin
        int bad;
        logic [31:0] w;

        repeat (3) tick();
        check("rst_ready", {31'd0, spi_ready}, 32'd1);
        check("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check("rst_clk", {31'd0, spi_clk}, 32'd1);
        check("rst_mosi", {31'd0, spi_mosi}, 32'd0);
        reset = 1'b0;

        bad = 0;
        repeat (20) begin
            command = $urandom;
            tick();
            if (!(spi_ready && spi_cs_n && spi_clk && !spi_mosi)) bad++;
        end
        check("idle_20", bad, 0);

        send_frame(32'h0040_1C21, 1'b0, 32'h1234_5678, 1'b0, 32'h0000_00A5, 1'b0);

        send_frame(32'h0040_4000, 1'b1, 32'hFFFF_FFFF, 1'b0, $urandom, 1'b0);
        send_frame(32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, $urandom, 1'b1);

        repeat (3) tick();
        for (int k = 0; k < 15; k++) begin
            send_frame(seq[k], k < 14, (k < 14) ? seq[k + 1] : 32'h0, 1'b0, $urandom, k > 0);
        end

        begin
`ifdef ADAU_SPI_READBACK_EN
            int rv0;
`endif
            repeat (2) tick();
            miso_word     = $urandom;
            command       = $urandom;
            command_valid = 1'b1;
            wait_accept();
            command_valid = 1'b0;
            repeat (100) tick();
`ifdef ADAU_SPI_READBACK_EN
            rv0 = rv_high;
`endif
            #2 reset = 1'b1;
            #1;
            check("abort_cs_n", {31'd0, spi_cs_n}, 32'd1);
            check("abort_clk", {31'd0, spi_clk}, 32'd1);
            check("abort_ready", {31'd0, spi_ready}, 32'd1);
            repeat (2) tick();
            reset = 1'b0;
            bad = 0;
            repeat (10) begin
                tick();
                if (!(spi_ready && spi_cs_n && spi_clk)) bad++;
            end
            check("no_resume", bad, 0);
`ifdef ADAU_SPI_READBACK_EN
            check("abort_no_read_valid", rv_high - rv0, 0);
            check("abort_read_data", {24'd0, read_data}, 32'd0);
`endif
            send_frame($urandom, 1'b0, $urandom, 1'b0, $urandom, 1'b0);
        end

        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 4)) tick();
            w = $urandom;
            if (r == 0) w = 32'h0;
            if (r == 1) w = 32'hFFFF_FFFF;
            send_frame(w, 1'b0, $urandom, 1'b1, $urandom, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
